// File: rtl/pic_pkg.sv
// Shared constants and types for the irq_controller interrupt controller.
package pic_pkg;

  localparam logic [15:0] PIC_CMD = 16'd0;
  localparam logic [15:0] PIC_IMR = 16'd1;
  localparam logic [15:0] PIC_ISR = 16'd2;

  localparam logic [7:0] EOI_NONSPEC = 8'h20;
  localparam logic [4:0] EOI_SPEC    = 5'b01100;
  localparam logic [3:0] NO_IRQ      = 4'd8;

  typedef enum logic {
    StIdle,
    StWaitAck
  } pic_state_e;

  typedef enum logic [1:0] {
    CmdNone,
    CmdEoiNonSpec,
    CmdEoiSpec
  } pic_cmd_e;

  function automatic pic_cmd_e pic_decode_cmd(logic [7:0] data);
    if (data == EOI_NONSPEC) return CmdEoiNonSpec;
    if (data[7:3] == EOI_SPEC) return CmdEoiSpec;
    return CmdNone;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Core-side I/O port bus and interrupt toggle handshake of irq_controller.
interface irq_controller_if;
  logic [15:0] port;
  logic        port_clk;
  logic        port_w;
  logic [7:0]  port_o;
  logic [7:0]  port_i;
  logic [7:0]  irq;
  logic        intr;
  logic        intl;

  modport master (
    output port, port_clk, port_w, port_o, intl,
    input  port_i, irq, intr
  );

  modport slave (
    input  port, port_clk, port_w, port_o, intl,
    output port_i, irq, intr
  );
endinterface

// File: rtl/pic_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit of an 8-bit vector.
module pic_prio_enc (
  input  logic [7:0] i_vec,
  output logic       o_valid,
  output logic [2:0] o_idx
);

  always_comb begin
    o_valid = 1'b0;
    o_idx   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (i_vec[k]) begin
        o_valid = 1'b1;
        o_idx   = 3'(k);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// 8-input programmable interrupt controller with toggle request handshake.
// Build option IRQ_AUTO_EOI_EN: acknowledged interrupts never enter the in-service register.
module irq_controller
  import pic_pkg::*;
#(
  parameter logic [15:0] BASE_PORT = 16'h0020,
  parameter logic [7:0]  VEC_RESET = 8'h08
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       irq_in,
  irq_controller_if.slave  bus
);

  logic [7:0] r_irr, r_isr, r_imr, r_irq_prev, r_irq;
  logic [4:0] r_vec_hi;
  logic [2:0] r_idx;
  logic       r_intr, r_port_clk_prev;
  pic_state_e r_state, w_state_d;

  logic [7:0]  w_rise, w_ack_mask, w_isr_set, w_eoi_clr;
  logic        w_p_valid, w_s_valid, w_in_sync, w_fire, w_ack;
  logic [2:0]  w_p_idx, w_s_idx;
  logic [3:0]  w_s_rank;
  logic [15:0] w_off;
  logic        w_wr, w_wr_cmd, w_wr_imr, w_wr_vec;

  assign w_rise = irq_in & ~r_irq_prev;

  pic_prio_enc u_pend_enc (
    .i_vec   (r_irr & ~r_imr),
    .o_valid (w_p_valid),
    .o_idx   (w_p_idx)
  );

  pic_prio_enc u_isr_enc (
    .i_vec   (r_isr),
    .o_valid (w_s_valid),
    .o_idx   (w_s_idx)
  );

  assign w_s_rank  = w_s_valid ? {1'b0, w_s_idx} : NO_IRQ;
  assign w_in_sync = (r_intr == bus.intl);

  // A request is outstanding while intr differs from intl; intl catching up is the ack.
  always_comb begin
    w_state_d = r_state;
    w_fire    = 1'b0;
    w_ack     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_in_sync && w_p_valid && ({1'b0, w_p_idx} < w_s_rank)) begin
          w_fire    = 1'b1;
          w_state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (w_in_sync) begin
          w_ack     = 1'b1;
          w_state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  assign w_off    = bus.port - BASE_PORT;
  assign w_wr     = bus.port_clk & ~r_port_clk_prev & bus.port_w;
  assign w_wr_cmd = w_wr && (w_off == PIC_CMD);
  assign w_wr_imr = w_wr && (w_off == PIC_IMR);
  assign w_wr_vec = w_wr && (w_off == PIC_ISR);

  assign w_ack_mask = w_ack ? (8'h01 << r_idx) : 8'h00;

`ifdef IRQ_AUTO_EOI_EN
  logic w_unused_cmd;
  assign w_unused_cmd = w_wr_cmd;
  assign w_isr_set    = 8'h00;
  assign w_eoi_clr    = 8'h00;
`else
  assign w_isr_set = w_ack_mask;

  // Non-specific EOI targets the ISR as it stood before any same-cycle ack.
  always_comb begin
    w_eoi_clr = 8'h00;
    if (w_wr_cmd) begin
      unique case (pic_decode_cmd(bus.port_o))
        CmdEoiNonSpec: if (w_s_valid) w_eoi_clr[w_s_idx] = 1'b1;
        CmdEoiSpec:    w_eoi_clr[bus.port_o[2:0]] = 1'b1;
        default:       ;
      endcase
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_irr           <= 8'h00;
      r_isr           <= 8'h00;
      r_imr           <= 8'hFF;
      r_vec_hi        <= VEC_RESET[7:3];
      r_irq           <= 8'h00;
      r_irq_prev      <= irq_in;
      r_intr          <= bus.intl;
      r_idx           <= 3'd0;
      r_port_clk_prev <= bus.port_clk;
    end else begin
      r_irq_prev      <= irq_in;
      r_port_clk_prev <= bus.port_clk;
      r_irr           <= (r_irr & ~w_ack_mask) | w_rise;
      r_isr           <= (r_isr | w_isr_set) & ~w_eoi_clr;
      if (w_wr_imr) r_imr <= bus.port_o;
      if (w_wr_vec) r_vec_hi <= bus.port_o[7:3];
      if (w_fire) begin
        r_irq  <= {r_vec_hi, w_p_idx};
        r_intr <= ~r_intr;
        r_idx  <= w_p_idx;
      end
    end
  end

  assign bus.irq  = r_irq;
  assign bus.intr = r_intr;

  always_comb begin
    bus.port_i = 8'h00;
    case (w_off)
      PIC_CMD: bus.port_i = r_irr;
      PIC_IMR: bus.port_i = r_imr;
      PIC_ISR: bus.port_i = r_isr;
      default: bus.port_i = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Randomized self-checking bench for irq_controller against a behavioural model.
module tb_irq_controller;

  localparam logic [15:0] BASE = 16'h0020;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq_in  = 8'h00;

  irq_controller_if bus ();

  irq_controller #(
    .BASE_PORT (BASE),
    .VEC_RESET (8'h08)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .irq_in  (irq_in),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Reference model state
  bit [7:0] m_irr, m_isr, m_imr, m_vec, m_irq, m_prev;
  bit       m_intr, m_wait, m_prev_clk;
  int       m_idx;
  bit       auto_ack;
  int       n_pass, n_checks;

  function automatic int lowest(bit [7:0] v);
    for (int k = 0; k < 8; k++) if (v[k]) return k;
    return 8;
  endfunction

  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_step();
    bit [7:0]    n_irr, n_isr, d;
    bit [15:0]   off;
    int          p, s;
    bit          sync, ack, fire, wr;
    if (!reset_n) begin
      m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_vec = 8'h08; m_irq = 0;
      m_prev = irq_in; m_intr = bus.intl; m_wait = 0; m_prev_clk = bus.port_clk;
      return;
    end
    sync = (m_intr == bus.intl);
    ack  = m_wait && sync;
    p    = lowest(m_irr & ~m_imr);
    s    = lowest(m_isr);
    fire = !m_wait && sync && (p < s);
    n_irr = m_irr;
    n_isr = m_isr;
    if (ack) begin
      n_irr[m_idx] = 0;
`ifdef IRQ_AUTO_EOI_EN
`else
      n_isr[m_idx] = 1;
`endif
      m_wait = 0;
    end
    n_irr = n_irr | (irq_in & ~m_prev);
    if (fire) begin
      m_irq  = {m_vec[7:3], 3'(p)};
      m_intr = !m_intr;
      m_idx  = p;
      m_wait = 1;
    end
    wr  = bus.port_clk && !m_prev_clk && bus.port_w;
    off = bus.port - BASE;
    d   = bus.port_o;
    if (wr && off == 0) begin
`ifdef IRQ_AUTO_EOI_EN
`else
      if (d == 8'h20) begin
        if (s < 8) n_isr[s] = 0;
      end else if (d[7:3] == 5'b01100) begin
        n_isr[d[2:0]] = 0;
      end
`endif
    end
    if (wr && off == 1) m_imr = d;
    if (wr && off == 2) m_vec = d & 8'hF8;
    m_irr = n_irr;
    m_isr = n_isr;
    m_prev = irq_in;
    m_prev_clk = bus.port_clk;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check("intr", {7'b0, bus.intr}, {7'b0, m_intr});
    check("irq", bus.irq, m_irq);
    if (auto_ack && (m_intr != bus.intl) && ($urandom_range(0, 2) == 0)) bus.intl = m_intr;
  endtask

  task automatic read_regs();
    logic [15:0] save;
    save = bus.port;
    bus.port = BASE;      #1 check("rd_irr", bus.port_i, m_irr);
    bus.port = BASE + 1;  #1 check("rd_imr", bus.port_i, m_imr);
    bus.port = BASE + 2;  #1 check("rd_isr", bus.port_i, m_isr);
    bus.port = BASE + 3;  #1 check("rd_unsel", bus.port_i, 8'h00);
    bus.port = save;
  endtask

  task automatic port_write(input logic [15:0] off, input logic [7:0] data);
    bus.port   = BASE + off;
    bus.port_o = data;
    bus.port_w = 1'b1;
    tick();
    bus.port_clk = 1'b1;
    tick();
    bus.port_clk = 1'b0;
    bus.port_w   = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic read_const(string tag, input logic [15:0] off, input logic [7:0] exp);
    bus.port = BASE + off;
    #1 check(tag, bus.port_i, exp);
  endtask

  initial begin
    bus.port = 16'h0; bus.port_clk = 1'b0; bus.port_w = 1'b0; bus.port_o = 8'h0; bus.intl = 1'b0;
    auto_ack = 1'b0;
    n_pass = 0;
    n_checks = 0;

    // 1: basic request on IRQ0
    do_reset();
    read_const("rst_imr", 1, 8'hFF);
    read_regs();
    port_write(1, 8'hFE);
    irq_in = 8'h01;
    tick();
    check("t1_no_early", {7'b0, bus.intr}, 8'h00);
    tick();
    check("t1_intr", {7'b0, bus.intr}, 8'h01);
    check("t1_vec", bus.irq, 8'h08);
    bus.intl = 1'b1;
    tick();
    irq_in = 8'h00;
`ifdef IRQ_AUTO_EOI_EN
    read_const("t1_isr", 2, 8'h00);
`else
    read_const("t1_isr", 2, 8'h01);
`endif
    read_const("t1_irr", 0, 8'h00);
    port_write(0, 8'h20);

`ifndef IRQ_AUTO_EOI_EN
    // 2: in-service IRQ3 blocks IRQ5 until EOI
    port_write(1, 8'h00);
    irq_in = 8'h08;
    tick(); tick();
    check("t2_vec3", bus.irq, 8'h0B);
    bus.intl = 1'b0;
    tick();
    irq_in = 8'h00;
    tick();
    irq_in = 8'h20;
    tick(); tick(); tick();
    check("t2_blocked", {7'b0, bus.intr}, 8'h00);
    port_write(0, 8'h20);
    check("t2_intr", {7'b0, bus.intr}, 8'h01);
    check("t2_vec5", bus.irq, 8'h0D);
    bus.intl = 1'b1;
    tick();
    irq_in = 8'h00;
    port_write(0, 8'h65);
    read_const("t2_isr", 2, 8'h00);

    // 3: simultaneous IRQ2/IRQ6
    irq_in = 8'h44;
    tick(); tick();
    check("t3_vec2", bus.irq, 8'h0A);
    bus.intl = 1'b0;
    tick();
    irq_in = 8'h00;
    tick();
    read_const("t3_isr", 2, 8'h04);
    port_write(0, 8'h20);
    check("t3_vec6", bus.irq, 8'h0E);
    bus.intl = 1'b1;
    tick();
    port_write(0, 8'h20);
`endif

    // 4: masking does not retract a pending request
    port_write(1, 8'h00);
    irq_in = 8'h02;
    tick(); tick();
    irq_in = 8'h00;
    port_write(1, 8'hFF);
    check("t4_vec1", bus.irq, 8'h09);
    check("t4_held", {7'b0, bus.intr}, {7'b0, ~bus.intl});
    bus.intl = m_intr;
    tick();
    read_const("t4_irr", 0, 8'h00);
    port_write(0, 8'h20);

    // 5: intl held high through reset
    bus.intl = 1'b1;
    do_reset();
    check("t5_intr", {7'b0, bus.intr}, 8'h01);
    port_write(1, 8'hFE);
    check("t5_quiet", {7'b0, bus.intr}, 8'h01);
    irq_in = 8'h01;
    tick(); tick();
    check("t5_toggle", {7'b0, bus.intr}, 8'h00);
    bus.intl = 1'b0;
    tick();
    irq_in = 8'h00;
    port_write(0, 8'h20);

`ifdef IRQ_AUTO_EOI_EN
    // 6: auto-EOI re-request
    port_write(1, 8'hEF);
    irq_in = 8'h10;
    tick(); tick();
    check("t6_vec4", bus.irq, 8'h0C);
    bus.intl = m_intr;
    tick();
    irq_in = 8'h00;
    read_const("t6_isr", 2, 8'h00);
    tick();
    irq_in = 8'h10;
    tick(); tick();
    check("t6_rereq", {7'b0, bus.intr}, {7'b0, ~bus.intl});
    bus.intl = m_intr;
    tick();
`endif

    // Randomized traffic with a core that acknowledges after a random delay
    auto_ack = 1'b1;
    for (int it = 0; it < 2500; it++) begin
      int op;
      irq_in = 8'($urandom & $urandom & $urandom);
      op = $urandom_range(0, 24);
      case (op)
        0: port_write(0, 8'h20);
        1: port_write(0, {5'b01100, 3'($urandom_range(0, 7))});
        2: port_write(1, 8'($urandom & $urandom));
        3: port_write(2, 8'($urandom));
        4: read_regs();
        5: port_write(0, 8'($urandom));
        6: port_write(3, 8'($urandom));
        7: begin
          if ($urandom_range(0, 7) == 0) begin
            bus.intl = 1'($urandom_range(0, 1));
            do_reset();
          end else begin
            tick();
          end
        end
        default: tick();
      endcase
    end
    auto_ack = 1'b0;
    read_regs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
